// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_CODES[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver: selects a digit, blanks,
// then shows the captured nibble for a fixed slot before moving on.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] num,
  input  logic [3:0] dp_in,
  input  logic [3:0] digit_mask,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       dec_c;

  // Decode at the capture edge so seg is already valid on the first SHOW cycle
  hex_to_seg7 u_dec (
    .hex   (num),
    .seg_c (dec_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        sel   <= '0;
        an    <= AN_OFF;
        seg   <= SEG_OFF;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= SHOW;
              cnt   <= '0;
              if (digit_mask[sel]) begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
              end else begin
                an  <= ~(4'b0001 << sel);
                seg <= {~dp_in[sel], dec_c};
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state      <= BLANK;
              cnt        <= '0;
              sel        <= sel + 2'd1;
              an         <= AN_OFF;
              seg        <= SEG_OFF;
              frame_tick <= (sel == 2'd3);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= '0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a cycle-level reference model of the scan timeline.
module tb_seg7_scan_driver;

  localparam int B     = 2;
  localparam int S     = 4;
  localparam int SLOT  = B + S;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] num;
  logic [3:0] dp_in = 4'h0;
  logic [3:0] digit_mask = 4'h0;
  logic [1:0] sel;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_tick;

  logic [3:0] digits [4];

  // External 4:1 nibble mux driven by the DUT's select
  assign num = digits[sel];

  seg7_scan_driver #(.SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .num        (num),
    .dp_in      (dp_in),
    .digit_mask (digit_mask),
    .sel        (sel),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: time since scan start and what was latched at the slot's capture point
  bit         running = 1'b0;
  int         t = 0;
  logic [3:0] m_num = 4'h0;
  logic       m_dp = 1'b0;
  logic       m_mask = 1'b0;

  function automatic logic [6:0] hex_code(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: sample inputs, advance the model across the edge, compare all outputs
  task automatic step();
    logic       s_rst, s_en;
    logic [3:0] s_num, s_dp, s_mask;
    int         slot, pos;
    logic [1:0] e_sel;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_tick;
    #1;
    s_rst = rst_n; s_en = en; s_num = num; s_dp = dp_in; s_mask = digit_mask;
    @(posedge clk);
    cyc++;
    e_sel = 2'd0; e_an = 4'hF; e_seg = 8'hFF; e_tick = 1'b0;
    if (!s_rst || !s_en) begin
      running = 1'b0;
    end else begin
      if (!running) begin
        running = 1'b1;
        t = 0;
      end else begin
        t++;
      end
      slot = (t / SLOT) % 4;
      pos  = t % SLOT;
      if (pos == B) begin
        m_num  = s_num;
        m_dp   = s_dp[slot];
        m_mask = s_mask[slot];
      end
      e_sel  = 2'(slot);
      e_tick = (t > 0) && (t % FRAME == 0);
      if (pos >= B && !m_mask) begin
        e_an[slot] = 1'b0;
        e_seg = {~m_dp, hex_code(m_num)};
      end
    end
    #1;
    chk("sel", 8'(sel), 8'(e_sel));
    chk("an", 8'(an), 8'(e_an));
    chk("seg", seg, e_seg);
    chk("frame_tick", 8'(frame_tick), 8'(e_tick));
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v);
    int n = 0;
    while (an !== v && n < 40) begin
      step();
      n++;
    end
    chk("wait_an", 8'(an), 8'(v));
  endtask

  task automatic wait_tick(output int at);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("wait_tick", 8'(frame_tick), 8'd1);
    at = cyc;
    step();
  endtask

  initial begin
    int t1, t2, e_count;
    digits[0] = 4'h1; digits[1] = 4'h2; digits[2] = 4'h3; digits[3] = 4'h4;
    @(negedge clk);

    // Reset state
    step();
    chk("rst_an", 8'(an), 8'h0F);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_tick", 8'(frame_tick), 8'h00);
    rst_n = 1'b1;
    step();
    chk("idle_an", 8'(an), 8'h0F);

    // Basic scan of 1,2,3,4
    en = 1'b1;
    step();
    chk("blank_an", 8'(an), 8'h0F);
    wait_an(4'hE); chk("d0_seg", seg, 8'hF9);
    wait_an(4'hD); chk("d1_seg", seg, 8'hA4);
    wait_an(4'hB); chk("d2_seg", seg, 8'hB0);
    wait_an(4'h7); chk("d3_seg", seg, 8'h99);
    wait_tick(t1);
    wait_tick(t2);
    chk("tick_period", 8'(t2 - t1), 8'd24);

    // Decimal point on digit 2 only, all digits 8
    en = 1'b0; step();
    for (int i = 0; i < 4; i++) digits[i] = 4'h8;
    dp_in = 4'b0100;
    en = 1'b1; step();
    wait_an(4'hE); chk("dp_d0", seg, 8'h80);
    wait_an(4'hB); chk("dp_d2", seg, 8'h00);
    wait_an(4'h7); chk("dp_d3", seg, 8'h80);

    // Digit 0 masked; slot timing unchanged
    en = 1'b0; step();
    dp_in = 4'h0;
    digits[0] = 4'h1; digits[1] = 4'h2; digits[2] = 4'h3; digits[3] = 4'h4;
    digit_mask = 4'b0001;
    en = 1'b1; step();
    e_count = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (an == 4'hE) e_count++;
    end
    chk("mask_no_d0", 8'(e_count), 8'd0);
    wait_an(4'hD); chk("mask_d1", seg, 8'hA4);
    wait_tick(t1);
    wait_tick(t2);
    chk("mask_period", 8'(t2 - t1), 8'd24);

    // num changes mid-SHOW of digit 1: held until the next capture
    en = 1'b0; step();
    digit_mask = 4'h0;
    digits[1] = 4'h5;
    en = 1'b1; step();
    wait_an(4'hD); chk("hold_first", seg, 8'h92);
    step();
    digits[1] = 4'hA;
    step();
    chk("hold_mid", seg, 8'h92);
    wait_an(4'hF);
    wait_an(4'hD); chk("hold_new", seg, 8'h88);

    // en dropped mid-SHOW of digit 2, then re-enabled
    wait_an(4'hB);
    step();
    en = 1'b0;
    step();
    chk("dis_an", 8'(an), 8'h0F);
    chk("dis_seg", seg, 8'hFF);
    chk("dis_sel", 8'(sel), 8'h00);
    en = 1'b1;
    step(); step();
    chk("reen_blank", 8'(an), 8'h0F);
    step();
    chk("reen_an", 8'(an), 8'h0E);
    chk("reen_seg", seg, 8'hF9);

    // Asynchronous reset mid-SHOW of digit 3
    wait_an(4'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", 8'(an), 8'h0F);
    chk("arst_seg", seg, 8'hFF);
    chk("arst_sel", 8'(sel), 8'h00);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_blank", 8'(an), 8'h0F);
    step();
    chk("post_rst_an", 8'(an), 8'h0E);
    for (int i = 0; i < FRAME; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
